// File: rtl/mvu_act_feeder.sv
// Activation feeder for an MVU PE array: streams each input vector once (FILL) and replays it NF-1 times (REPLAY).
// Optional macro MVU_ACT_FEEDER_PASSCNT_EN adds out_nf_cnt, the pass index registered alongside each word.
module mvu_act_feeder #(
    parameter int SIMD    = 2,
    parameter int TI      = 4,
    parameter int MATRIXW = 8,
    parameter int MATRIXH = 4,
    parameter int PE      = 2,
    localparam int W      = SIMD * TI,
    localparam int SF     = MATRIXW / SIMD,
    localparam int NF     = MATRIXH / PE,
    localparam int SF_W   = (SF > 1) ? $clog2(SF) : 1,
    localparam int NF_W   = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_v,
    input  logic [W-1:0]    in_act,
    output logic            in_rdy,
    output logic            out_v,
    output logic [W-1:0]    out_act,
    input  logic            out_rdy,
    output logic            out_sf_first,
    output logic            out_sf_last
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
    ,
    output logic [NF_W-1:0] out_nf_cnt
`endif
);

    localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);

    typedef enum logic {FILL, REPLAY} state_t;

    state_t            state_q, state_d;
    logic [SF_W-1:0]   sf_cnt_q, sf_cnt_d;
    logic [NF_W-1:0]   nf_cnt_q, nf_cnt_d;
    logic              out_v_q, out_v_d;
    logic [W-1:0]      out_act_q, out_act_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [W-1:0]      buf_q [SF];
    logic              buf_we;
    logic              load_slot;
    logic              advance;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
    logic [NF_W-1:0]   nf_out_q, nf_out_d;
`endif

    // In FILL the buffer is only written and in REPLAY only read, so no same-entry write/read overlap.
    always_comb begin
        state_d   = state_q;
        sf_cnt_d  = sf_cnt_q;
        nf_cnt_d  = nf_cnt_q;
        out_v_d   = out_v_q;
        out_act_d = out_act_q;
        first_d   = first_q;
        last_d    = last_q;
        buf_we    = 1'b0;
        advance   = 1'b0;
        load_slot = !out_v_q || out_rdy;
        in_rdy    = (state_q == FILL) && load_slot;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
        nf_out_d  = nf_out_q;
`endif
        if (load_slot) begin
            if (state_q == FILL) begin
                if (in_v) begin
                    buf_we    = 1'b1;
                    out_v_d   = 1'b1;
                    out_act_d = in_act;
                    advance   = 1'b1;
                end else begin
                    out_v_d = 1'b0;
                end
            end else begin
                out_v_d   = 1'b1;
                out_act_d = buf_q[sf_cnt_q];
                advance   = 1'b1;
            end
        end

        if (advance) begin
            first_d = (sf_cnt_q == '0);
            last_d  = (sf_cnt_q == SF_LAST);
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
            nf_out_d = nf_cnt_q;
`endif
            if (sf_cnt_q == SF_LAST) begin
                sf_cnt_d = '0;
                if (state_q == FILL) begin
                    // With a single pass the feeder never leaves FILL.
                    if (NF > 1) begin
                        state_d  = REPLAY;
                        nf_cnt_d = NF_W'(1);
                    end
                end else if (nf_cnt_q == NF_LAST) begin
                    state_d  = FILL;
                    nf_cnt_d = '0;
                end else begin
                    nf_cnt_d = nf_cnt_q + NF_W'(1);
                end
            end else begin
                sf_cnt_d = sf_cnt_q + SF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            sf_cnt_q  <= '0;
            nf_cnt_q  <= '0;
            out_v_q   <= 1'b0;
            out_act_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
            nf_out_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sf_cnt_q  <= sf_cnt_d;
            nf_cnt_q  <= nf_cnt_d;
            out_v_q   <= out_v_d;
            out_act_q <= out_act_d;
            first_q   <= first_d;
            last_q    <= last_d;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
            nf_out_q  <= nf_out_d;
`endif
        end
    end

    // Vector storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[sf_cnt_q] <= in_act;
        end
    end

    assign out_v        = out_v_q;
    assign out_act      = out_act_q;
    assign out_sf_first = first_q;
    assign out_sf_last  = last_q;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
    assign out_nf_cnt   = nf_out_q;
`endif

endmodule

// File: tb/tb_mvu_act_feeder.sv
// Self-checking bench for mvu_act_feeder: queue-based model of fill/replay passes plus scenario tasks.
// Honours MVU_ACT_FEEDER_PASSCNT_EN when defined for the build.
module tb_mvu_act_feeder;

  localparam int SIMD = 2, TI = 4, MATRIXW = 8, MATRIXH = 4, PE = 2;
  localparam int W   = SIMD * TI;
  localparam int SF  = MATRIXW / SIMD;
  localparam int NF  = MATRIXH / PE;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
  localparam int IW  = W + 2 + NFW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_v = 1'b0;
  logic [W-1:0] in_act = '0;
  logic         in_rdy;
  logic         out_v;
  logic [W-1:0] out_act;
  logic         out_rdy = 1'b1;
  logic         out_sf_first;
  logic         out_sf_last;
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
  logic [NFW-1:0] out_nf_cnt;
`endif

  mvu_act_feeder #(
    .SIMD(SIMD), .TI(TI), .MATRIXW(MATRIXW), .MATRIXH(MATRIXH), .PE(PE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_v(in_v),
    .in_act(in_act),
    .in_rdy(in_rdy),
    .out_v(out_v),
    .out_act(out_act),
    .out_rdy(out_rdy),
    .out_sf_first(out_sf_first),
    .out_sf_last(out_sf_last)
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
    ,
    .out_nf_cnt(out_nf_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int beats = 0;
  logic rand_rdy = 1'b0;

  // reference model: expected output items {nf, first, last, act}
  logic [IW-1:0] exp_q[$];
  logic [W-1:0]  vec_q[$];
  int            replay_left = 0;
  logic          m_ov = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  end

  // scoreboard: compares every cycle at the falling edge, then advances the model
  always @(negedge clk) begin : monitor
    logic [IW-1:0] item;
    logic exp_rdy, slot, acc, rl_nz;
    int idx;
    if (!rst_n) begin
      exp_q.delete();
      vec_q.delete();
      replay_left = 0;
      m_ov = 1'b0;
    end else begin
      exp_rdy = (replay_left == 0) && (!m_ov || out_rdy);
      total++;
      if (out_v !== m_ov) begin
        bad++;
        $display("FAIL out_v: got %b want %b at %0t", out_v, m_ov, $time);
      end
      total++;
      if (in_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL in_rdy: got %b want %b at %0t", in_rdy, exp_rdy, $time);
      end
      if (m_ov && out_rdy) begin
        beats++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got act=%h want none at %0t", out_act, $time);
        end else begin
          item = exp_q.pop_front();
          if ({out_sf_first, out_sf_last, out_act} !== item[W+1:0]) begin
            bad++;
            $display("FAIL beat: got first=%b last=%b act=%h want first=%b last=%b act=%h at %0t",
                     out_sf_first, out_sf_last, out_act, item[W+1], item[W], item[W-1:0], $time);
          end
`ifdef MVU_ACT_FEEDER_PASSCNT_EN
          total++;
          if (out_nf_cnt !== item[IW-1 -: NFW]) begin
            bad++;
            $display("FAIL nf_cnt: got %0d want %0d at %0t", out_nf_cnt, item[IW-1 -: NFW], $time);
          end
`endif
        end
      end
      slot  = !m_ov || out_rdy;
      acc   = in_v && exp_rdy;
      rl_nz = (replay_left > 0);
      if (acc) begin
        vec_q.push_back(in_act);
        idx = vec_q.size() - 1;
        exp_q.push_back({NFW'(0), idx == 0, idx == SF - 1, in_act});
        if (vec_q.size() == SF) begin
          for (int p = 1; p < NF; p++)
            for (int k = 0; k < SF; k++)
              exp_q.push_back({NFW'(p), k == 0, k == SF - 1, vec_q[k]});
          replay_left = SF * (NF - 1);
          vec_q.delete();
        end
      end else if (slot && rl_nz) begin
        replay_left--;
      end
      if (slot) m_ov = acc || rl_nz;
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] w, output int waits);
    waits = 0;
    in_v = 1'b1;
    in_act = w;
    @(negedge clk);
    while (!in_rdy && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_rdy=0 want 1 word=%h", w);
      in_v = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    total++;
    if (out_v !== 1'b1 || out_act !== w) begin
      bad++;
      $display("FAIL latency: got v=%b act=%h want v=1 act=%h", out_v, out_act, w);
    end
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_ov) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    total++;
    if ({out_v, out_act, out_sf_first, out_sf_last, in_rdy} !== {1'b0, W'(0), 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset: got v=%b act=%h f=%b l=%b rdy=%b want v=0 act=00 f=0 l=0 rdy=1",
               out_v, out_act, out_sf_first, out_sf_last, in_rdy);
    end
  endtask

  task automatic test_basic();
    int wt;
    logic [W-1:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) send(words[i], wt);
    for (int i = 0; i < SF * (NF - 1); i++) begin
      @(negedge clk);
      total++;
      if (in_rdy !== 1'b0) begin
        bad++;
        $display("FAIL replay_rdy: got %b want 0 cycle %0d", in_rdy, i);
      end
    end
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL refill_rdy: got %b want 1", in_rdy);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_stall();
    int wt;
    send(8'h11, wt);
    send(8'h22, wt);
    out_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({out_v, out_act, out_sf_first, out_sf_last, in_rdy} !== {1'b1, 8'h22, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold: got v=%b act=%h f=%b l=%b rdy=%b want v=1 act=22 f=0 l=0 rdy=0",
                 out_v, out_act, out_sf_first, out_sf_last, in_rdy);
      end
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    send(8'h33, wt);
    send(8'h44, wt);
    drain();
  endtask

  task automatic test_gaps();
    int wt;
    for (int i = 0; i < SF; i++) begin
      send(W'($urandom_range(0, 255)), wt);
      if (i < SF - 1) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (out_v !== 1'b0) begin
          bad++;
          $display("FAIL gap_out_v: got %b want 0 word %0d", out_v, i);
        end
        @(posedge clk);
        #1;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int wt, b0;
    logic [W-1:0] words [8];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    words[4] = 8'hA1; words[5] = 8'hA2; words[6] = 8'hA3; words[7] = 8'hA4;
    b0 = beats;
    for (int i = 0; i < 8; i++) begin
      send(words[i], wt);
      if (i == 4) begin
        total++;
        if (wt !== SF * (NF - 1)) begin
          bad++;
          $display("FAIL b2b_wait: got %0d want %0d", wt, SF * (NF - 1));
        end
      end
    end
    drain();
    total++;
    if (beats - b0 !== 2 * SF * NF) begin
      bad++;
      $display("FAIL b2b_beats: got %0d want %0d", beats - b0, 2 * SF * NF);
    end
  endtask

  task automatic test_reset_mid();
    int wt;
    for (int i = 0; i < SF; i++) send(W'($urandom_range(0, 255)), wt);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    total++;
    if (out_v !== 1'b0 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1", out_v, in_rdy);
    end
    send(8'h5C, wt);
    total++;
    if (out_sf_first !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_first: got %b want 1", out_sf_first);
    end
    for (int i = 1; i < SF; i++) send(W'($urandom_range(0, 255)), wt);
    drain();
  endtask

  task automatic test_random();
    int wt;
    rand_rdy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < SF; i++) begin
        send(W'($urandom), wt);
        idle($urandom_range(0, 3));
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_rdy = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d queued items want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL global_timeout: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
